// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32 main controller: states, opcodes,
// ALU classes, datapath mux selects and the select bundle driven by the FSM.
package ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWRITE = 4'd4;
    localparam state_t S_MEMWB    = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BEQ      = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_TRAP     = 4'd11;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic ADR_PC     = 1'b0;
    localparam logic ADR_RESULT = 1'b1;

    typedef struct packed {
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_sel_t;

    // Fetch-phase selects double as the idle/trap values for any unnamed select.
    localparam ctrl_sel_t SEL_FETCH = '{
        adr_src:    ADR_PC,
        alu_src_a:  SRCA_PC,
        alu_src_b:  SRCB_FOUR,
        result_src: RES_ALU,
        alu_op:     ALU_ADD
    };

    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait cycle counter: clears on request, counts enabled cycles and
// saturates, with a registered done flag once the count equals WAIT_MAX.
module wait_timer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (enable && (count != CNT_W'(WAIT_MAX))) begin
            count_next = count + CNT_W'(1);
        end
    end

    // done is registered from the next count so it lines up with count itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            count <= count_next;
            done  <= (count_next == CNT_W'(WAIT_MAX));
        end
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32 main controller: Mealy write strobes, Moore datapath selects,
// sticky trap flags. Define CTRL_JAL_EN to include the JAL state.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       illegal_instr,
    output logic       bus_error
);

    state_t    state;
    state_t    state_next;
    ctrl_sel_t sel;

    logic pc_write_c;
    logic ir_write_c;
    logic mem_write_c;
    logic reg_write_c;
    logic ill_set;
    logic berr_set;
    logic tmr_clear;
    logic tmr_enable;
    logic tmr_done;

    wait_timer #(
        .WAIT_MAX(WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .done   (tmr_done)
    );

    // Any state change restarts the count, so every wait state is entered at zero.
    assign tmr_clear  = (state_next != state);
    assign tmr_enable = is_wait_state(state) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next state and write strobes; a timed-out wait raises no strobe.
    always_comb begin
        state_next  = state;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        ill_set     = 1'b0;
        berr_set    = 1'b0;

        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_next = S_DECODE;
                end else if (tmr_done) begin
                    berr_set   = 1'b1;
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BEQ;
`ifdef CTRL_JAL_EN
                    OP_JAL:            state_next = S_JAL;
`endif
                    default: begin
                        ill_set    = 1'b1;
                        state_next = S_TRAP;
                    end
                endcase
            end
            S_MEMADR: begin
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (tmr_done) begin
                    berr_set   = 1'b1;
                    state_next = S_TRAP;
                end
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    mem_write_c = 1'b1;
                    state_next  = S_FETCH;
                end else if (tmr_done) begin
                    berr_set   = 1'b1;
                    state_next = S_TRAP;
                end else begin
                    mem_write_c = 1'b1;
                end
            end
            S_MEMWB: begin
                reg_write_c = 1'b1;
                state_next  = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_next  = S_FETCH;
            end
            S_BEQ: begin
                pc_write_c = zero;
                state_next = S_FETCH;
            end
`ifdef CTRL_JAL_EN
            S_JAL: begin
                pc_write_c = 1'b1;
                state_next = S_ALUWB;
            end
`endif
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // Moore select decode from the state register alone.
    always_comb begin
        sel = SEL_FETCH;
        case (state)
            S_DECODE: begin
                sel.alu_src_a = SRCA_OLDPC;
                sel.alu_src_b = SRCB_IMM;
                sel.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                sel.alu_src_a = SRCA_RS1;
                sel.alu_src_b = SRCB_IMM;
                sel.alu_op    = ALU_ADD;
            end
            S_MEMREAD, S_MEMWRITE: begin
                sel.adr_src    = ADR_RESULT;
                sel.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                sel.result_src = RES_DATA;
            end
            S_EXECR: begin
                sel.alu_src_a = SRCA_RS1;
                sel.alu_src_b = SRCB_RS2;
                sel.alu_op    = ALU_FUNCT;
            end
            S_EXECI: begin
                sel.alu_src_a = SRCA_RS1;
                sel.alu_src_b = SRCB_IMM;
                sel.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                sel.result_src = RES_ALUOUT;
            end
            S_BEQ: begin
                sel.alu_src_a  = SRCA_RS1;
                sel.alu_src_b  = SRCB_RS2;
                sel.alu_op     = ALU_SUB;
                sel.result_src = RES_ALUOUT;
            end
`ifdef CTRL_JAL_EN
            S_JAL: begin
                sel.alu_src_a  = SRCA_OLDPC;
                sel.alu_src_b  = SRCB_FOUR;
                sel.alu_op     = ALU_ADD;
                sel.result_src = RES_ALUOUT;
            end
`endif
            default: begin
                sel = SEL_FETCH;
            end
        endcase
    end

    // Trap causes stay set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            if (ill_set) begin
                illegal_instr <= 1'b1;
            end
            if (berr_set) begin
                bus_error <= 1'b1;
            end
        end
    end

    // Strobes are held low for the whole time reset is asserted.
    assign pc_write   = rst_n & pc_write_c;
    assign ir_write   = rst_n & ir_write_c;
    assign mem_write  = rst_n & mem_write_c;
    assign reg_write  = rst_n & reg_write_c;

    assign adr_src    = sel.adr_src;
    assign alu_src_a  = sel.alu_src_a;
    assign alu_src_b  = sel.alu_src_b;
    assign result_src = sel.result_src;
    assign alu_op     = sel.alu_op;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: an instruction-level model expands each
// scenario into per-cycle {inputs, expected outputs} vectors that are replayed.
module tb_control_fsm;

    localparam int unsigned WAIT_MAX = 15;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JALOP  = 7'b1101111;

    // select word layout: {adr_src, alu_src_a, alu_src_b, result_src, alu_op}
    localparam logic [8:0] M_ALL    = 9'b1_11_11_11_11;
    localparam logic [8:0] M_ABALU  = 9'b0_11_11_00_11;
    localparam logic [8:0] M_ADRRES = 9'b1_00_00_11_00;
    localparam logic [8:0] M_RES    = 9'b0_00_00_11_00;
    localparam logic [8:0] M_ABRA   = 9'b0_11_11_11_11;
    localparam logic [8:0] SEL_FET  = {1'b0, 2'b00, 2'b10, 2'b10, 2'b00};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, mem_write, reg_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic       illegal_instr, bus_error;

    control_fsm #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .adr_src       (adr_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .alu_op        (alu_op),
        .illegal_instr (illegal_instr),
        .bus_error     (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [6:0] op;
        logic       zero;
        logic       rdy;
        logic [3:0] stb;   // {pc_write, ir_write, mem_write, reg_write}
        logic [8:0] sel;
        logic [8:0] msk;
        logic       ill;
        logic       berr;
    } vec_t;

    typedef struct {
        logic [6:0] op;
        logic       z;
        int         fw;
        int         mw;
    } scen_t;

    vec_t  vq[$];
    scen_t dir[12];
    int    errors = 0;
    int    checks = 0;
    int    vidx = 0;
    logic  m_ill = 1'b0;
    logic  m_berr = 1'b0;

    function automatic logic [8:0] mk_sel(input logic adr, input logic [1:0] a, input logic [1:0] b,
                                          input logic [1:0] res, input logic [1:0] alu);
        return {adr, a, b, res, alu};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d t=%0t got=%h want=%h", name, vidx, $time, act, exp);
        end
    endtask

    task automatic push(input logic [6:0] o, input logic z, input logic r, input logic [3:0] stb,
                        input logic [8:0] sel, input logic [8:0] msk);
        vec_t v;
        v.rst_n = 1'b1; v.op = o; v.zero = z; v.rdy = r;
        v.stb = stb; v.sel = sel; v.msk = msk; v.ill = m_ill; v.berr = m_berr;
        vq.push_back(v);
    endtask

    task automatic push_reset();
        vec_t v;
        v.rst_n = 1'b0; v.op = 7'($urandom); v.zero = 1'($urandom); v.rdy = 1'($urandom);
        v.stb = 4'b0; v.sel = SEL_FET; v.msk = M_ALL; v.ill = 1'b0; v.berr = 1'b0;
        vq.push_back(v);
        m_ill = 1'b0;
        m_berr = 1'b0;
    endtask

    task automatic push_trap(input int n);
        for (int i = 0; i < n; i++)
            push(7'($urandom), 1'($urandom), 1'($urandom), 4'b0, SEL_FET, M_ALL);
    endtask

    // kind: 0 fetch, 1 memory read, 2 memory write; n = cycles with mem_ready low
    task automatic wait_phase(input int kind, input logic [6:0] o, input logic z, input int n,
                              output bit trapped);
        logic [8:0] s, m;
        logic [3:0] idle_stb, done_stb;
        s = (kind == 0) ? SEL_FET : mk_sel(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
        m = (kind == 0) ? M_ALL : M_ADRRES;
        idle_stb = (kind == 2) ? 4'b0010 : 4'b0000;
        done_stb = (kind == 0) ? 4'b1100 : idle_stb;
        if (n > int'(WAIT_MAX)) begin
            for (int k = 0; k < int'(WAIT_MAX); k++) push(o, z, 1'b0, idle_stb, s, m);
            push(o, z, 1'b0, 4'b0000, s, m);
            m_berr = 1'b1;
            trapped = 1'b1;
        end else begin
            for (int k = 0; k < n; k++) push(o, z, 1'b0, idle_stb, s, m);
            push(o, z, 1'b1, done_stb, s, m);
            trapped = 1'b0;
        end
    endtask

    task automatic build_instr(input logic [6:0] o, input logic z, input int fw, input int mw);
        bit t;
        wait_phase(0, o, z, fw, t);
        if (t) begin
            push_trap(3);
            push_reset();
            return;
        end
        push(o, z, 1'($urandom), 4'b0, mk_sel(1'b0, 2'b01, 2'b01, 2'b00, 2'b00), M_ABALU);
        case (o)
            LOAD, STORE: begin
                push(o, z, 1'($urandom), 4'b0, mk_sel(1'b0, 2'b10, 2'b01, 2'b00, 2'b00), M_ABALU);
                wait_phase(o[5] ? 2 : 1, o, z, mw, t);
                if (t) begin
                    push_trap(3);
                    push_reset();
                end else if (o == LOAD) begin
                    push(o, z, 1'($urandom), 4'b0001, mk_sel(1'b0, 2'b00, 2'b00, 2'b01, 2'b00), M_RES);
                end
            end
            RTYPE, ITYPE: begin
                push(o, z, 1'($urandom), 4'b0,
                     mk_sel(1'b0, 2'b10, (o == ITYPE) ? 2'b01 : 2'b00, 2'b00, 2'b10), M_ABALU);
                push(o, z, 1'($urandom), 4'b0001, mk_sel(1'b0, 2'b00, 2'b00, 2'b00, 2'b00), M_RES);
            end
            BRANCH: begin
                push(o, z, 1'($urandom), {z, 3'b000}, mk_sel(1'b0, 2'b10, 2'b00, 2'b00, 2'b01), M_ABRA);
            end
`ifdef CTRL_JAL_EN
            JALOP: begin
                push(o, z, 1'($urandom), 4'b1000, mk_sel(1'b0, 2'b01, 2'b10, 2'b00, 2'b00), M_ABRA);
                push(o, z, 1'($urandom), 4'b0001, mk_sel(1'b0, 2'b00, 2'b00, 2'b00, 2'b00), M_RES);
            end
`endif
            default: begin
                m_ill = 1'b1;
                push_trap(3);
                push_reset();
            end
        endcase
    endtask

    task automatic run_queue();
        vec_t v;
        while (vq.size() > 0) begin
            v = vq.pop_front();
            rst_n = v.rst_n; op = v.op; zero = v.zero; mem_ready = v.rdy;
            @(negedge clk);
            check("strobes", 9'({pc_write, ir_write, mem_write, reg_write}), 9'(v.stb));
            check("selects", {adr_src, alu_src_a, alu_src_b, result_src, alu_op} & v.msk, v.sel & v.msk);
            check("flags", 9'({illegal_instr, bus_error}), 9'({v.ill, v.berr}));
            vidx++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit t;
        logic [6:0] ops[6];
        dir[0]  = '{RTYPE,      1'b0, 0, 0};
        dir[1]  = '{LOAD,       1'b0, 0, 3};
        dir[2]  = '{BRANCH,     1'b1, 0, 0};
        dir[3]  = '{BRANCH,     1'b0, 0, 0};
        dir[4]  = '{STORE,      1'b0, 0, 40};
        dir[5]  = '{7'b1111111, 1'b0, 0, 0};
        dir[6]  = '{JALOP,      1'b0, 1, 0};
        dir[7]  = '{ITYPE,      1'b1, 2, 0};
        dir[8]  = '{LOAD,       1'b0, 0, int'(WAIT_MAX)};
        dir[9]  = '{STORE,      1'b0, 1, int'(WAIT_MAX)};
        dir[10] = '{RTYPE,      1'b0, int'(WAIT_MAX), 0};
        dir[11] = '{ITYPE,      1'b0, int'(WAIT_MAX) + 1, 0};
        ops = '{LOAD, STORE, RTYPE, ITYPE, BRANCH, JALOP};

        rst_n = 1'b0; op = 7'b0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        push_reset();
        push_reset();
        for (int i = 0; i < 12; i++) build_instr(dir[i].op, dir[i].z, dir[i].fw, dir[i].mw);
        run_queue();

        // Reset pulsed in the middle of a store wait.
        push_reset();
        wait_phase(0, STORE, 1'b0, 0, t);
        push(STORE, 1'b0, 1'b1, 4'b0, mk_sel(1'b0, 2'b01, 2'b01, 2'b00, 2'b00), M_ABALU);
        push(STORE, 1'b0, 1'b1, 4'b0, mk_sel(1'b0, 2'b10, 2'b01, 2'b00, 2'b00), M_ABALU);
        push(STORE, 1'b0, 1'b0, 4'b0010, mk_sel(1'b1, 2'b00, 2'b00, 2'b00, 2'b00), M_ADRRES);
        push(STORE, 1'b0, 1'b0, 4'b0010, mk_sel(1'b1, 2'b00, 2'b00, 2'b00, 2'b00), M_ADRRES);
        run_queue();
        op = STORE; zero = 1'b0; mem_ready = 1'b0; rst_n = 1'b1;
        #2;
        check("memwrite_before_reset", 9'(mem_write), 9'b1);
        rst_n = 1'b0;
        #1;
        check("strobes_in_reset", 9'({pc_write, ir_write, mem_write, reg_write}), 9'b0);
        check("selects_in_reset", {adr_src, alu_src_a, alu_src_b, result_src, alu_op}, SEL_FET);
        check("flags_in_reset", 9'({illegal_instr, bus_error}), 9'b0);
        @(posedge clk);
        #1;
        m_ill = 1'b0;
        m_berr = 1'b0;
        build_instr(RTYPE, 1'b0, int'(WAIT_MAX), 0);
        run_queue();

        // Randomised instruction stream, occasionally straddling the wait limit.
        for (int i = 0; i < 60; i++) begin
            logic [6:0] o;
            int fw, mw;
            int sel_i;
            sel_i = int'($urandom_range(0, 6));
            o = (sel_i == 6) ? 7'($urandom) : ops[sel_i];
            fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(WAIT_MAX - 1, WAIT_MAX + 2))
                                             : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(WAIT_MAX - 1, WAIT_MAX + 2))
                                             : int'($urandom_range(0, 3));
            build_instr(o, 1'($urandom), fw, mw);
        end
        run_queue();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
